// File: rtl/seq_divider_restoring_pkg.sv
// Shared definitions for the restoring sequential divider: default sizing and FSM encoding.
package seq_divider_restoring_pkg;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_restoring_cla_sub.sv
// Carry-lookahead subtractor: o_diff = i_a + ~i_b + 1, o_borrow_n = 1 when i_a >= i_b.
module seq_divider_restoring_cla_sub #(
    parameter int unsigned N = 65
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_borrow_n
);

    localparam int unsigned LEVELS = $clog2(N);

    logic [N-1:0] w_b_n;
    logic [N-1:0] w_p;
    logic [N-1:0] w_g;
    logic [N:0]   w_c;
    logic [N-1:0] w_gp [0:LEVELS];
    logic [N-1:0] w_pp [0:LEVELS];

    // Parallel-prefix (Kogge-Stone) combine of generate/propagate pairs.
    always_comb begin
        w_b_n = ~i_b;
        w_p   = i_a ^ w_b_n;
        w_g   = i_a & w_b_n;
        for (int k = 0; k <= int'(LEVELS); k++) begin
            w_gp[k] = '0;
            w_pp[k] = '0;
        end
        w_gp[0]    = w_g;
        w_gp[0][0] = w_g[0] | w_p[0];  // carry-in of 1 folded into bit 0
        w_pp[0]    = w_p;
        for (int k = 0; k < int'(LEVELS); k++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (i >= (1 << k)) begin
                    w_gp[k+1][i] = w_gp[k][i] | (w_pp[k][i] & w_gp[k][i-(1<<k)]);
                    w_pp[k+1][i] = w_pp[k][i] & w_pp[k][i-(1<<k)];
                end else begin
                    w_gp[k+1][i] = w_gp[k][i];
                    w_pp[k+1][i] = w_pp[k][i];
                end
            end
        end
        w_c        = {w_gp[LEVELS], 1'b1};
        o_diff     = w_p ^ w_c[N-1:0];
        o_borrow_n = w_c[N];
    end

endmodule

// File: rtl/seq_divider_restoring.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider_restoring
    import seq_divider_restoring_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow_n;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_r_next;
    logic             w_unused;

    assign w_accept   = i_start && (r_state != ST_RUN);
    assign w_div_zero = (i_divisor == '0);
    assign w_last     = (r_cnt == '0);

    // The partial remainder stays below D, so it is held in WIDTH bits; the
    // shifted value S needs one extra bit and the difference fits back in WIDTH.
    assign w_s = {r_r, r_q[WIDTH-1]};

    seq_divider_restoring_cla_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a        (w_s),
        .i_b        ({1'b0, r_d}),
        .o_diff     (w_diff),
        .o_borrow_n (w_borrow_n)
    );

    assign w_q_next = {r_q[WIDTH-2:0], w_borrow_n};
    assign w_r_next = w_borrow_n ? w_diff[WIDTH-1:0] : w_s[WIDTH-1:0];
    assign w_unused = w_diff[WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_d = w_div_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                w_state_d = ST_IDLE;
                if (w_accept) w_state_d = w_div_zero ? ST_DONE : ST_RUN;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_d    <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quot <= '1;
                r_rem  <= i_dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_d   <= i_divisor;
                r_q   <= i_dividend;
                r_r   <= '0;
                r_cnt <= CNT_W'(WIDTH - 1);
            end
        end else if (r_state == ST_RUN) begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            if (w_last) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
                r_dbz  <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_quotient    = r_quot;
    assign o_remainder   = r_rem;
    assign o_div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider_restoring.md
Name: seq_divider_restoring

Overview:
- Unsigned restoring sequential divider; the inverse operation of the sequential multiplier in the same arithmetic subsystem.
- Produces one quotient bit per clock. Each trial subtraction is done by a carry-lookahead subtractor, computed as a + ~b + 1 with generate/propagate chains.
- Driven by a start/busy/done handshake from the same controller that drives the multiplier.

Parameters:
- WIDTH, 64, operand/quotient/remainder width in bits (WIDTH >= 2).
- CNT_W, 7, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset; one clock domain only
- start  input  1  request pulse; sampled only when busy==0
- dividend  input  WIDTH  unsigned numerator, captured on accepted start
- divisor  input  WIDTH  unsigned denominator, captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset (rst=1 at an edge, overrides everything, including mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, exactly one cycle.
- Accept: start=1 at an edge with state IDLE or DONE, allowing back-to-back operations. start is ignored in RUN.
- Accept with divisor!=0:
  - D<=divisor, Q<=dividend, R<=0 ((WIDTH+1)-bit), counter<=WIDTH-1, state->RUN.
- Accept with divisor==0:
  - state->DONE at that edge.
  - quotient<=all ones, remainder<=dividend, div_by_zero<=1.
  - done is high in the next cycle (latency 1).
- RUN, each edge performs one iteration:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}, WIDTH+1 bits.
  - T = S + ~{0,D} + 1, computed by the subtractor; borrow_n = carry out.
  - If borrow_n=1: R<=T, Q<={Q[WIDTH-2:0],1}. Otherwise: R<=S, Q<={Q[WIDTH-2:0],0}.
  - R < D holds invariantly, so S < 2D and fits in WIDTH+1 bits; no overflow.
- Termination: on the iteration edge where counter==0, i.e. the WIDTH-th RUN edge:
  - quotient<=final Q, remainder<=final R[WIDTH-1:0], div_by_zero<=0, state->DONE.
  - Otherwise counter decrements.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(WIDTH) (64 for the default); busy is high for exactly WIDTH cycles.
- Output hold: quotient/remainder/div_by_zero hold until the next completion or reset. They do not change on an accepted start.
- Input capture: dividend/divisor changes after the accept edge have no effect.
- Simultaneous events: rst and start at the same edge → reset wins. start during DONE → accepted, and done drops the next cycle.

Decomposition:
- Shared package: WIDTH default; CNT_W; state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One natural sub-module: carry_lookahead_subtractor.
  - Parameterised width WIDTH+1; inputs a, b.
  - Outputs diff and borrow_n, where borrow_n=1 means a>=b.
  - Internally a + ~b with cin=1, using a P/G/C lookahead chain.
- Top module holds the FSM, counter and shift registers.

Test Plan:
- Basic division: dividend=100, divisor=7, start pulse → busy high 64 cycles; done pulse at cycle 64 after accept; quotient=14, remainder=2, div_by_zero=0.
- Maximum dividend: dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=1 → quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0. Then dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=0xFFFF_FFFF_FFFF_FFFF → quotient=1, remainder=0.
- Small dividend: dividend=5, divisor=9 → quotient=0, remainder=5. Also dividend=0x8000_0000_0000_0000, divisor=3 → quotient=0x2AAA_AAAA_AAAA_AAAA, remainder=2.
- Division by zero: dividend=42, divisor=0 → done high the cycle after accept; quotient=all ones, remainder=42, div_by_zero=1, busy never high.
- Busy-time stimulus: start re-pulsed with 9/2 at cycle 10 of a 100/7 run → ignored; result still 14 r 2. Back-to-back start during the DONE cycle with 9/2 → accepted; quotient=4, remainder=1 after 64 more cycles.
- Reset mid-run: rst=1 at cycle 30 of a run → next cycle busy=0, done=0, quotient=0, remainder=0. A subsequent 100/7 completes normally.
